vram_port_arbiter: RTL and testbench
====================================

Name: vram_port_arbiter

Overview:
- Shares video_memory port A (17-bit address, 8-bit data, 1-cycle read latency) between NUM_REQ requesters: graphics instruction engine (req 0), block fill/copy engine (req 1) and CPU direct-access window (req 2).
- Performs round-robin arbitration with at most one access per cycle.
- Supports an optional lock for read-modify-write sequences.
- Returns read data to the requester that issued the read, tagged by a valid strobe.

Parameters:
- NUM_REQ, 3, number of requesters (2..4).
- ADDR_W, 17, video memory address width.
- DATA_W, 8, video memory data width.
- RD_LAT, 1, memory read latency in cycles from registered address to mem_dout.

Ports:
- video_clk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  access request per requester; held until granted.
- lock  in  NUM_REQ  keep ownership after this grant.
- we  in  NUM_REQ  1 = write, 0 = read; per requester.
- addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  flattened write data.
- gnt  out  NUM_REQ  one-hot combinational grant in the cycle the access is accepted.
- rvalid  out  NUM_REQ  one-hot read-data-valid strobe.
- rdata  out  DATA_W  read data, shared; meaningful only with rvalid.
- mem_addr  out  ADDR_W  registered address to video_memory addra.
- mem_din  out  DATA_W  registered write data to dina.
- mem_we  out  1  registered write enable to wea.
- mem_dout  in  DATA_W  douta from video_memory.

Behaviour:
- Reset: gnt=0, rvalid=0, mem_addr=0, mem_din=0, mem_we=0, rr pointer=0, state=ARB, read-tag pipeline cleared. Reset mid-operation drops all in-flight reads; no rvalid is issued for them.
- States: ARB and LOCKED(owner).
- ARB:
  - Winner is the first asserted req[i] searching from pointer upward, mod NUM_REQ.
  - gnt[winner]=1 in the same cycle; at most one gnt bit is set.
  - With no req asserted, gnt=0 and mem_we=0 at the next edge.
- On a grant in cycle T:
  - At the end of T: mem_addr/mem_din/mem_we are loaded from the winner's fields, and pointer = winner+1 mod NUM_REQ.
  - If lock[winner]=1, the next state is LOCKED(winner).
- LOCKED(owner):
  - Only the owner can be granted; other requests wait.
  - Pointer is frozen.
  - Returns to ARB at the edge where lock[owner]=0 (sampled every cycle, granted or not).
  - A grant in the cycle lock drops is still performed.
- Read return: for a read granted in cycle T, rvalid[winner]=1 in cycle T+1+RD_LAT (T+2 at default), with rdata=mem_dout (combinational pass-through). Writes produce no rvalid.
- Tag pipeline depth RD_LAT+1 holds {valid, one-hot id}.
- Back-to-back grants are allowed every cycle; reads and writes may interleave freely.
- Read-after-write to the same address in consecutive grants returns the new data (memory is read-first per access order).
- Requester contract: hold req/we/addr/wdata stable until gnt; deassert req or present the next access in the cycle after gnt. Dropping req before gnt withdraws the request silently.
- Starvation bound: an unlocked requester waits at most NUM_REQ-1 grants.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- When defined, adds:
  - Output wait_cnt (NUM_REQ*16): per requester, a 16-bit saturating counter incremented each cycle req[i]=1 and gnt[i]=0. Saturates at 16'hFFFF.
  - Input stats_clr (1): synchronous clear of all counters; clear takes priority over increment.
- Counters reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single read: req0 read addr 17'h00100 with memory preloaded to 8'h5A -> gnt0 in T, mem_addr=17'h00100 and mem_we=0 in T+1, rvalid=3'b001 and rdata=8'h5A in T+2.
- Contention: req=3'b111 held continuously after reset -> grant order 0,1,2,0,1,2 on consecutive cycles, one-hot each cycle.
- Lock: req1 with lock1=1 for 3 accesses (read 17'h1FFFF, write 8'hC3, read) while req0 and req2 are asserted -> gnt1 on 3 consecutive grants, gnt0/gnt2 low; after lock1 drops, the next grant is 2; second read returns 8'hC3.
- Write then read: req2 write 8'hA7 to 17'h0ABCD, then read the same address on the next grant -> mem_we pulse 1 cycle, no rvalid for the write, rvalid=3'b100 with rdata=8'hA7.
- Reset mid-read: assert reset_n=0 one cycle after gnt0 of a read -> all outputs 0 immediately, no rvalid after release; pointer restarts at 0.
- With VRAM_ARB_STATS_EN: req=3'b011 held for 10 cycles -> wait_cnt0=5 and wait_cnt1=5; stats_clr pulse -> both 0 next cycle.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: round-robin arbiter sharing video_memory port A among
// NUM_REQ requesters, with a read-modify-write lock and tagged read return.
// Optional per-requester wait statistics are built when VRAM_ARB_STATS_EN is defined.
module vram_port_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                       video_clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_din,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_dout
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      wait_cnt,
    input  logic                       stats_clr
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_e;

    state_e               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     owner_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_din_q;
    logic                 mem_we_q;
    // Read-tag pipeline: one-hot requester id, all-zero means no read in that slot
    logic [NUM_REQ-1:0]   tag_q [RD_LAT+1];

    logic                 grant_v;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     cand;
    logic [NUM_REQ-1:0]   gnt_c;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_we;
    logic                 sel_lock;
    logic [PTR_W-1:0]     ptr_nxt;

    // Winner selection: owner only while locked, else first request from the pointer upward
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state_q == ST_LOCKED) begin
            grant_v   = req[owner_q];
            grant_idx = owner_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
                if (!grant_v && req[cand]) begin
                    grant_v   = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Grant vector and field mux for the selected requester
    always_comb begin
        gnt_c     = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_v && (PTR_W'(i) == grant_idx)) begin
                gnt_c[i]  = 1'b1;
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                sel_we    = we[i];
                sel_lock  = lock[i];
            end
        end
        ptr_nxt = PTR_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
    end

    // Arbiter state, pointer, memory port registers and read-tag pipeline
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mem_we_q <= grant_v && sel_we;
            if (grant_v) begin
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_wdata;
            end
            tag_q[0] <= (grant_v && !sel_we) ? gnt_c : '0;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            case (state_q)
                ST_ARB: begin
                    if (grant_v) begin
                        ptr_q <= ptr_nxt;
                        if (sel_lock) begin
                            state_q <= ST_LOCKED;
                            owner_q <= grant_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!lock[owner_q]) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Grant is combinational but forced low while reset is asserted
    assign gnt      = reset_n ? gnt_c : '0;
    assign rvalid   = tag_q[RD_LAT];
    assign rdata    = mem_dout;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;

`ifdef VRAM_ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0] wait_cnt_q;

    // Saturating per-requester wait counters; clear wins over increment
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    wait_cnt_q[i*CNT_W +: CNT_W] <= '0;
                end else if (req[i] && !gnt_c[i] && (wait_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    wait_cnt_q[i*CNT_W +: CNT_W] <= wait_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Testbench for vram_port_arbiter: behavioural video memory, read-return
// scoreboard and one task per scenario.
`timescale 1ns/1ps
module tb_vram_port_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RD_LAT  = 1;

    typedef struct {
        logic [NUM_REQ-1:0] id;
        logic [DATA_W-1:0]  data;
        int                 cyc;
    } exp_t;

    logic                      video_clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req, lock, we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt, rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_din;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_dout;
`ifdef VRAM_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     wait_cnt;
    logic                      stats_clr;
`endif

    logic                      pre_we;
    logic [ADDR_W-1:0]         pre_addr;
    logic [DATA_W-1:0]         pre_data;
    logic [DATA_W-1:0]         ram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]         shadow [0:(1<<ADDR_W)-1];

    exp_t                      sb[$];
    int                        n_vec = 0;
    int                        n_err = 0;
    int                        cyc   = 0;
    logic [NUM_REQ-1:0]        g_obs;
    logic [ADDR_W-1:0]         ma_obs;
    logic [DATA_W-1:0]         md_obs;
    logic                      mwe_obs;

    vram_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .video_clk (video_clk),
        .reset_n   (reset_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout)
`ifdef VRAM_ARB_STATS_EN
        ,
        .wait_cnt  (wait_cnt),
        .stats_clr (stats_clr)
`endif
    );

    always #5 video_clk = ~video_clk;

    // Read-first single-port memory with one cycle of read latency
    always @(posedge video_clk) begin
        mem_dout <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_din;
        if (pre_we) ram[pre_addr] <= pre_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic r, input logic w, input logic l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i]  = r;
        we[i]   = w;
        lock[i] = l;
        addr[i*ADDR_W +: ADDR_W]  = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_req();
        req  = '0;
        lock = '0;
        we   = '0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        shadow[a] = d;
        @(posedge video_clk);
        #1;
        pre_we = 1'b0;
    endtask

    // One cycle: sample at the falling edge, check read returns, log new grants, advance
    task automatic step();
        exp_t e;
        @(negedge video_clk);
        cyc++;
        g_obs   = gnt;
        ma_obs  = mem_addr;
        md_obs  = mem_din;
        mwe_obs = mem_we;
        if (rvalid !== '0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rvalid_spurious cyc=%0d got rvalid=%b rdata=%h exp rvalid=000", cyc, rvalid, rdata);
            end else begin
                e = sb.pop_front();
                if (rvalid !== e.id || rdata !== e.data || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL read_return got rvalid=%b rdata=%h cyc=%0d exp rvalid=%b rdata=%h cyc=%0d",
                             rvalid, rdata, cyc, e.id, e.data, e.cyc);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            n_vec++;
            n_err++;
            e = sb.pop_front();
            $display("FAIL read_missing cyc=%0d got rvalid=000 exp rvalid=%b rdata=%h", cyc, e.id, e.data);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] === 1'b1) begin
                logic [ADDR_W-1:0] a;
                a = addr[i*ADDR_W +: ADDR_W];
                if (we[i]) begin
                    shadow[a] = wdata[i*DATA_W +: DATA_W];
                end else begin
                    e.id   = NUM_REQ'(1 << i);
                    e.data = shadow[a];
                    e.cyc  = cyc + 1 + int'(RD_LAT);
                    sb.push_back(e);
                end
            end
        end
        @(posedge video_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_req();
        sb.delete();
        repeat (2) @(posedge video_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain(input int n);
        clear_req();
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = '1;
        we  = '0;
        #3;
        n_vec++;
        if ({gnt, rvalid, mem_addr, mem_din, mem_we} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got gnt=%b rvalid=%b mem_addr=%h mem_din=%h mem_we=%b exp all zero",
                     gnt, rvalid, mem_addr, mem_din, mem_we);
        end
        do_reset();
        step();
        n_vec++;
        if (g_obs !== '0 || mwe_obs !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got gnt=%b mem_we=%b exp gnt=000 mem_we=0", g_obs, mwe_obs);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        preload(17'h00100, 8'h5A);
        set_req(0, 1'b1, 1'b0, 1'b0, 17'h00100, 8'h00);
        step();
        n_vec++;
        if (g_obs !== 3'b001) begin
            n_err++;
            $display("FAIL single_read_gnt got %b exp 001", g_obs);
        end
        clear_req();
        step();
        n_vec++;
        if (ma_obs !== 17'h00100 || mwe_obs !== 1'b0 || g_obs !== 3'b000) begin
            n_err++;
            $display("FAIL single_read_port got addr=%h we=%b gnt=%b exp addr=00100 we=0 gnt=000", ma_obs, mwe_obs, g_obs);
        end
        drain(3);
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] exp_g;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, 1'b1, 1'b0, ADDR_W'(32'h400 + i), DATA_W'(8'h10 + i));
        end
        for (int k = 0; k < 6; k++) begin
            step();
            exp_g = NUM_REQ'(1 << (k % NUM_REQ));
            n_vec++;
            if (g_obs !== exp_g) begin
                n_err++;
                $display("FAIL contention_gnt[%0d] got %b exp %b", k, g_obs, exp_g);
            end
        end
        drain(3);
    endtask

    task automatic test_lock();
        logic [NUM_REQ-1:0] exp_g [5];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b010;
        exp_g[3] = 3'b010; exp_g[4] = 3'b100;
        do_reset();
        preload(17'h1FFFF, 8'h3C);
        // Move the pointer to requester 1
        set_req(0, 1'b1, 1'b1, 1'b0, 17'h00010, 8'h01);
        step();
        set_req(1, 1'b1, 1'b0, 1'b1, 17'h1FFFF, 8'h00);
        set_req(2, 1'b1, 1'b1, 1'b0, 17'h00020, 8'h02);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            n_vec++;
            if (g_obs !== exp_g[k]) begin
                n_err++;
                $display("FAIL lock_gnt[%0d] got %b exp %b", k, g_obs, exp_g[k]);
            end
            if (k == 1) set_req(1, 1'b1, 1'b1, 1'b1, 17'h1FFFF, 8'hC3);
            if (k == 2) set_req(1, 1'b1, 1'b0, 1'b0, 17'h1FFFF, 8'h00);
            if (k == 3) set_req(1, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00);
        end
        drain(4);
    endtask

    task automatic test_write_then_read();
        do_reset();
        set_req(2, 1'b1, 1'b1, 1'b0, 17'h0ABCD, 8'hA7);
        step();
        n_vec++;
        if (g_obs !== 3'b100) begin
            n_err++;
            $display("FAIL wr_gnt got %b exp 100", g_obs);
        end
        set_req(2, 1'b1, 1'b0, 1'b0, 17'h0ABCD, 8'h00);
        step();
        n_vec++;
        if (g_obs !== 3'b100 || mwe_obs !== 1'b1 || ma_obs !== 17'h0ABCD || md_obs !== 8'hA7) begin
            n_err++;
            $display("FAIL wr_port got gnt=%b we=%b addr=%h din=%h exp gnt=100 we=1 addr=0abcd din=a7",
                     g_obs, mwe_obs, ma_obs, md_obs);
        end
        clear_req();
        step();
        n_vec++;
        if (mwe_obs !== 1'b0) begin
            n_err++;
            $display("FAIL wr_pulse got mem_we=%b exp 0", mwe_obs);
        end
        drain(3);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        preload(17'h00300, 8'h77);
        set_req(0, 1'b1, 1'b0, 1'b0, 17'h00300, 8'h00);
        step();
        n_vec++;
        if (g_obs !== 3'b001) begin
            n_err++;
            $display("FAIL midrst_gnt got %b exp 001", g_obs);
        end
        clear_req();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({gnt, rvalid, mem_addr, mem_din, mem_we} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs got gnt=%b rvalid=%b mem_addr=%h mem_din=%h mem_we=%b exp all zero",
                     gnt, rvalid, mem_addr, mem_din, mem_we);
        end
        sb.delete();
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, 1'b1, 1'b0, ADDR_W'(32'h500 + i), 8'h00);
        end
        step();
        n_vec++;
        if (g_obs !== 3'b001) begin
            n_err++;
            $display("FAIL midrst_ptr got %b exp 001", g_obs);
        end
        drain(3);
    endtask

`ifdef VRAM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        stats_clr = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, 17'h00600, 8'h00);
        set_req(1, 1'b1, 1'b1, 1'b0, 17'h00601, 8'h00);
        repeat (10) step();
        clear_req();
        n_vec++;
        if (wait_cnt[15:0] !== 16'd5 || wait_cnt[31:16] !== 16'd5 || wait_cnt[47:32] !== 16'd0) begin
            n_err++;
            $display("FAIL stats_count got %h exp 0000_0005_0005", wait_cnt);
        end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        n_vec++;
        if (wait_cnt !== '0) begin
            n_err++;
            $display("FAIL stats_clear got %h exp 0", wait_cnt);
        end
        drain(2);
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        pre_we  = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        addr    = '0;
        wdata   = '0;
        clear_req();
`ifdef VRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_write_then_read();
        test_reset_mid_read();
`ifdef VRAM_ARB_STATS_EN
        test_stats();
`endif
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending reads exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
